// File: rtl/rs232_rx_pkt_ctrl_pkg.sv
// Shared constants, types and helper functions for the RS-232 packet controller.
package rs232_rx_pkt_ctrl_pkg;

    // Start-of-frame marker
    localparam logic [7:0] SOF_BYTE    = 8'hA5;

    // Error codes reported on err_code_o
    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_BADLEN  = 3'd1;
    localparam logic [2:0] ERR_NOSPACE = 3'd2;
    localparam logic [2:0] ERR_CHK     = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;

    // Frame parser states
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_LEN      = 2'd1;
    localparam logic [1:0] ST_DATA     = 2'd2;
    localparam logic [1:0] ST_CHK      = 2'd3;

    // One payload FIFO entry: byte plus end-of-packet marker
    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } pl_entry_t;

    // Whole clock cycles per bit on the line
    function automatic int clk_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Inter-byte gap limit in clock cycles (whole bit times, not rounded total)
    function automatic int timeout_clks(input int clk_hz, input int baud, input int bits);
        return bits * clk_per_bit(clk_hz, baud);
    endfunction

endpackage

// File: rtl/rs232_rx_pkt_ctrl_commit_fifo.sv
// Payload FIFO with a commit pointer: bytes become readable only once the
// frame that carried them is committed, and an aborted frame is rewound.
module rs232_commit_fifo
    import rs232_rx_pkt_ctrl_pkg::*;
#(
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
)
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en_i,
    input  pl_entry_t     wr_data_i,
    input  logic          commit_i,
    input  logic          rewind_i,
    input  logic          rd_en_i,
    output pl_entry_t     rd_data_o,
    output logic          valid_o,
    output logic [AW:0]   free_o
);

    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
    localparam logic [AW:0] DEPTH_VAL = (AW+1)'(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_commit_ptr;
    logic [AW:0] r_rd_ptr;
    pl_entry_t   r_mem [DEPTH];

    logic        w_valid;
    logic        w_rd_fire;

    // The read side only ever sees the committed region
    assign w_valid   = (r_rd_ptr != r_commit_ptr);
    assign w_rd_fire = rd_en_i & w_valid;

    // Payload storage, cleared on reset so nothing stale leaks out
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en_i) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data_i;
        end
    end

    // Write, commit and read pointers; a read may coincide with commit/rewind
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
        end else begin
            if (rewind_i) begin
                r_wr_ptr <= r_commit_ptr;
            end else if (wr_en_i) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (commit_i) begin
                r_commit_ptr <= r_wr_ptr;
            end
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    assign valid_o   = w_valid;
    assign rd_data_o = w_valid ? r_mem[r_rd_ptr[AW-1:0]] : '0;
    // Uncommitted bytes still occupy space, so free counts from rd_ptr
    assign free_o    = DEPTH_VAL - (r_wr_ptr - r_rd_ptr);

endmodule

// File: rtl/rs232_rx_pkt_ctrl.sv
// Packet controller behind the RS-232 byte receiver: parses SOF/LEN/payload/CHK
// frames, stores payload in a commit FIFO and releases only checksum-good
// packets on a valid/ready stream. Bad frames are dropped with an error code.
module rs232_rx_pkt_ctrl
    import rs232_rx_pkt_ctrl_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int BAUD         = 9600,
    parameter int TIMEOUT_BITS = 20,
    parameter int MAX_LEN      = 16,
    parameter int FIFO_DEPTH   = 32
)
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_strobe_i,
    input  logic [7:0] rx_data_i,
    output logic [7:0] pl_data_o,
    output logic       pl_last_o,
    output logic       pl_valid_o,
    input  logic       pl_ready_i,
    output logic       pkt_ok_o,
    output logic       pkt_err_o,
    output logic [2:0] err_code_o,
    output logic       busy_o
);

    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int TIMEOUT_CLKS = timeout_clks(CLK_HZ, BAUD, TIMEOUT_BITS);
    localparam int GW           = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CLKS - 1);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);

    // Registered state
    logic [1:0]    r_state;
    logic [7:0]    r_count;
    logic [7:0]    r_xor;
    logic [GW-1:0] r_gap;
    logic          r_pkt_ok;
    logic          r_pkt_err;
    logic [2:0]    r_err_code;
    logic          r_busy;

    // Next-state and FIFO control
    logic [1:0]    w_state_nxt;
    logic [7:0]    w_count_nxt;
    logic [7:0]    w_xor_nxt;
    logic          w_wr_en;
    logic          w_commit;
    logic          w_rewind;
    logic          w_ok;
    logic          w_err;
    logic [2:0]    w_err_code;
    logic          w_expire;
    logic          w_len_ok;
    logic          w_space_ok;
    logic [AW:0]   w_free;
    pl_entry_t     w_wr_entry;
    pl_entry_t     w_rd_entry;
    logic          w_valid;

    assign w_len_ok   = (rx_data_i != 8'd0) && (rx_data_i <= 8'(MAX_LEN));
    assign w_space_ok = (32'(w_free) >= 32'(rx_data_i));
    // A strobe in the expiry cycle wins over the timeout
    assign w_expire   = (r_state != ST_IDLE) && !rx_strobe_i && (r_gap == GAP_LAST);

    assign w_wr_entry.last = (r_count == 8'd1);
    assign w_wr_entry.data = rx_data_i;

    rs232_commit_fifo #(
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_en_i    (w_wr_en),
        .wr_data_i  (w_wr_entry),
        .commit_i   (w_commit),
        .rewind_i   (w_rewind),
        .rd_en_i    (pl_ready_i),
        .rd_data_o  (w_rd_entry),
        .valid_o    (w_valid),
        .free_o     (w_free)
    );

    // Frame parser: decides next state, FIFO actions and packet outcome
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_xor_nxt   = r_xor;
        w_wr_en     = 1'b0;
        w_commit    = 1'b0;
        w_rewind    = 1'b0;
        w_ok        = 1'b0;
        w_err       = 1'b0;
        w_err_code  = ERR_NONE;
        case (r_state)
            ST_IDLE: begin
                if (rx_strobe_i && (rx_data_i == SOF_BYTE)) begin
                    w_state_nxt = ST_LEN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LEN: begin
                if (rx_strobe_i) begin
                    if (!w_len_ok) begin
                        w_err       = 1'b1;
                        w_err_code  = ERR_BADLEN;
                        w_state_nxt = ST_IDLE;
                    end else if (!w_space_ok) begin
                        w_err       = 1'b1;
                        w_err_code  = ERR_NOSPACE;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_count_nxt = rx_data_i;
                        w_xor_nxt   = rx_data_i;
                        w_state_nxt = ST_DATA;
                    end
                end else begin
                    w_state_nxt = ST_LEN;
                end
            end
            ST_DATA: begin
                if (rx_strobe_i) begin
                    w_wr_en     = 1'b1;
                    w_xor_nxt   = r_xor ^ rx_data_i;
                    w_count_nxt = r_count - 8'd1;
                    if (r_count == 8'd1) begin
                        w_state_nxt = ST_CHK;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_CHK: begin
                if (rx_strobe_i) begin
                    if (rx_data_i == r_xor) begin
                        w_commit = 1'b1;
                        w_ok     = 1'b1;
                    end else begin
                        w_rewind   = 1'b1;
                        w_err      = 1'b1;
                        w_err_code = ERR_CHK;
                    end
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_CHK;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Timeout only fires on strobe-free cycles, so it never competes with the case above
        if (w_expire) begin
            w_rewind    = 1'b1;
            w_err       = 1'b1;
            w_err_code  = ERR_TIMEOUT;
            w_state_nxt = ST_IDLE;
        end else begin
            w_state_nxt = w_state_nxt;
        end
    end

    // Parser state, count and running checksum
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_count <= 8'd0;
            r_xor   <= 8'd0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_xor   <= w_xor_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Inter-byte gap counter: cleared by every strobe, runs only inside a frame
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_gap <= '0;
        end else if (rx_strobe_i || (r_state == ST_IDLE)) begin
            r_gap <= '0;
        end else begin
            r_gap <= r_gap + GAP_ONE;
        end
    end

    // Outcome pulses one cycle after the deciding strobe; code held until next error
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pkt_ok   <= 1'b0;
            r_pkt_err  <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_pkt_ok  <= w_ok;
            r_pkt_err <= w_err;
            if (w_err) begin
                r_err_code <= w_err_code;
            end
        end
    end

    assign pl_data_o  = w_rd_entry.data;
    assign pl_last_o  = w_rd_entry.last;
    assign pl_valid_o = w_valid;
    assign pkt_ok_o   = r_pkt_ok;
    assign pkt_err_o  = r_pkt_err;
    assign err_code_o = r_err_code;
    assign busy_o     = r_busy;

endmodule

// File: tb/tb_rs232_rx_pkt_ctrl.sv
// Self-checking bench for rs232_rx_pkt_ctrl: directed frames plus randomized
// frames, checked against a frame-level reference model and payload scoreboard.
module tb_rs232_rx_pkt_ctrl;

    localparam int CLK_HZ   = 1_000_000;
    localparam int BAUD     = 9600;
    localparam int TO_BITS  = 20;
    localparam int MAX_LEN  = 16;
    localparam int DEPTH    = 32;
    localparam int TO_CLKS  = TO_BITS * (CLK_HZ / BAUD);

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       rx_strobe = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       pl_ready = 1'b0;
    logic [7:0] pl_data;
    logic       pl_last;
    logic       pl_valid;
    logic       pkt_ok;
    logic       pkt_err;
    logic [2:0] err_code;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [8:0] expq[$];
    logic [7:0] tx_pl[$];
    int committed_total = 0;
    int pop_cnt = 0;
    int last_cnt = 0;
    int exp_ok = 0;
    int exp_err = 0;
    int n_ok_seen = 0;
    int n_err_seen = 0;
    int rdy_mode = 1;

    rs232_rx_pkt_ctrl #(
        .CLK_HZ       (CLK_HZ),
        .BAUD         (BAUD),
        .TIMEOUT_BITS (TO_BITS),
        .MAX_LEN      (MAX_LEN),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .rx_strobe_i  (rx_strobe),
        .rx_data_i    (rx_data),
        .pl_data_o    (pl_data),
        .pl_last_o    (pl_last),
        .pl_valid_o   (pl_valid),
        .pl_ready_i   (pl_ready),
        .pkt_ok_o     (pkt_ok),
        .pkt_err_o    (pkt_err),
        .err_code_o   (err_code),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Consumer ready pattern
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 2) pl_ready = ($urandom_range(0, 3) != 0);
        else               pl_ready = (rdy_mode == 1);
    end

    // Monitor: pulse counts and payload scoreboard
    always @(negedge clk) begin
        if (rst_i) begin
            if (pkt_ok)  n_ok_seen++;
            if (pkt_err) n_err_seen++;
            if (pl_valid && pl_ready) begin
                if (expq.size() == 0) begin
                    check_val("pl_unexpected", pl_valid, 1'b0);
                end else begin
                    check_val("pl_byte", {pl_last, pl_data}, expq.pop_front());
                    pop_cnt++;
                    if (pl_last) last_cnt++;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one byte for one cycle; returns in the cycle after it was sampled
    task automatic send_byte(input logic [7:0] b);
        rx_strobe = 1'b1;
        rx_data   = b;
        @(posedge clk);
        #1;
        rx_strobe = 1'b0;
        rx_data   = 8'h00;
    endtask

    task automatic send_junk(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h5A;
            send_byte(b);
            check_val("junk_busy", busy, 1'b0);
        end
    endtask

    // Send A5, len, tx_pl, chk and compare the outcome with the frame rules
    task automatic do_frame(input logic [7:0] len, input logic [7:0] chk, input int max_gap);
        int         free_m;
        int         code;
        logic [7:0] x;
        send_byte(8'hA5);
        check_val("sof_busy", busy, 1'b1);
        free_m = DEPTH - (committed_total - pop_cnt);
        x = len;
        foreach (tx_pl[i]) x = x ^ tx_pl[i];
        if (len == 8'd0 || int'(len) > MAX_LEN) code = 1;
        else if (free_m < int'(len))            code = 2;
        else if (chk != x)                      code = 3;
        else                                    code = 0;
        send_byte(len);
        if (code == 1 || code == 2) begin
            exp_err++;
            check_val("len_err", pkt_err, 1'b1);
            check_val("len_code", err_code, 3'(code));
            check_val("len_busy", busy, 1'b0);
        end else begin
            for (int i = 0; i < int'(len); i++) begin
                send_byte(tx_pl[i]);
                idle($urandom_range(0, max_gap));
            end
            if (code == 0) begin
                for (int i = 0; i < int'(len); i++) begin
                    expq.push_back({(i == int'(len) - 1), tx_pl[i]});
                end
                committed_total += int'(len);
                exp_ok++;
            end else begin
                exp_err++;
            end
            send_byte(chk);
            check_val("chk_ok", pkt_ok, (code == 0));
            check_val("chk_err", pkt_err, (code != 0));
            if (code != 0) check_val("chk_code", err_code, 3'(code));
            check_val("chk_busy", busy, 1'b0);
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && expq.size() != 0; i++) idle(1);
        idle(4);
        check_val(tag, expq.size(), 0);
    endtask

    initial begin
        int base_pop;
        int base_last;
        int len;
        logic [7:0] x;

        // Reset state
        idle(3);
        check_val("rst_valid", pl_valid, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_code", err_code, 3'd0);
        check_val("rst_ok", pkt_ok, 1'b0);
        rst_i = 1'b1;
        idle(2);

        // 1: good frame; checksum is LEN ^ payload = 03^11^22^33 = 03
        rdy_mode = 1;
        tx_pl = '{8'h11, 8'h22, 8'h33};
        do_frame(8'd3, 8'h03, 2);
        drain("t1_drain");

        // 2: same frame with wrong checksum, nothing becomes visible
        do_frame(8'd3, 8'h01, 2);
        idle(3);
        check_val("t2_valid", pl_valid, 1'b0);

        // 3: junk then BADLEN for 0 and 17
        send_junk(2);
        tx_pl = '{};
        do_frame(8'd0, 8'h00, 0);
        do_frame(8'd17, 8'h00, 0);

        // 4: fill the FIFO with the consumer stalled, then NOSPACE
        rdy_mode = 0;
        idle(2);
        base_pop  = pop_cnt;
        base_last = last_cnt;
        for (int f = 0; f < 2; f++) begin
            tx_pl = '{};
            for (int i = 0; i < 16; i++) tx_pl.push_back(8'($urandom_range(0, 255)));
            x = 8'd16;
            foreach (tx_pl[i]) x = x ^ tx_pl[i];
            do_frame(8'd16, x, 1);
        end
        tx_pl = '{8'h44};
        do_frame(8'd1, 8'h45, 0);
        check_val("t4_code", err_code, 3'd2);
        rdy_mode = 1;
        drain("t4_drain");
        check_val("t4_bytes", pop_cnt - base_pop, 32);
        check_val("t4_lasts", last_cnt - base_last, 2);

        // 5a: timeout after the gap limit of silence
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h11);
        idle(TO_CLKS - 1);
        check_val("t5_noerr_early", pkt_err, 1'b0);
        check_val("t5_busy_early", busy, 1'b1);
        idle(1);
        exp_err++;
        check_val("t5_err", pkt_err, 1'b1);
        check_val("t5_code", err_code, 3'd4);
        check_val("t5_busy", busy, 1'b0);
        idle(3);
        check_val("t5_valid", pl_valid, 1'b0);

        // 5b: strobe exactly in the expiry cycle keeps the frame alive
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h11);
        idle(TO_CLKS - 1);
        send_byte(8'h22);
        check_val("t5b_noerr", pkt_err, 1'b0);
        check_val("t5b_busy", busy, 1'b1);
        expq.push_back({1'b0, 8'h11});
        expq.push_back({1'b1, 8'h22});
        committed_total += 2;
        exp_ok++;
        send_byte(8'h02 ^ 8'h11 ^ 8'h22);
        check_val("t5b_ok", pkt_ok, 1'b1);
        drain("t5b_drain");

        // 6: reset mid-DATA with committed bytes pending
        rdy_mode = 0;
        idle(2);
        tx_pl = '{8'h01, 8'h02, 8'h03};
        do_frame(8'd3, 8'h03 ^ 8'h01 ^ 8'h02 ^ 8'h03, 0);
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'hAA);
        send_byte(8'hBB);
        #2;
        rst_i = 1'b0;
        #1;
        check_val("t6_valid", pl_valid, 1'b0);
        check_val("t6_data", {pl_last, pl_data}, 9'h000);
        check_val("t6_busy", busy, 1'b0);
        check_val("t6_ok", pkt_ok, 1'b0);
        check_val("t6_err", {pkt_err, err_code}, 4'h0);
        expq.delete();
        committed_total = 0;
        pop_cnt = 0;
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        rdy_mode = 1;
        idle(2);
        tx_pl = '{8'h5C, 8'hA5};
        do_frame(8'd2, 8'h02 ^ 8'h5C ^ 8'hA5, 1);
        drain("t6_drain");

        // Randomized frames
        rdy_mode = 2;
        for (int f = 0; f < 40; f++) begin
            send_junk($urandom_range(0, 2));
            if ($urandom_range(0, 99) < 10) len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 40);
            else                            len = $urandom_range(1, 16);
            tx_pl = '{};
            if (len >= 1 && len <= MAX_LEN) begin
                for (int i = 0; i < len; i++) tx_pl.push_back(8'($urandom_range(0, 255)));
            end
            x = 8'(len);
            foreach (tx_pl[i]) x = x ^ tx_pl[i];
            if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
            do_frame(8'(len), x, 3);
            idle($urandom_range(0, 4));
        end
        rdy_mode = 1;
        drain("rand_drain");
        check_val("ok_pulses", n_ok_seen, exp_ok);
        check_val("err_pulses", n_err_seen, exp_err);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
